// File: rtl/llr_pingpong_loader_if.sv
// Bus bundle for the LLR ping-pong loader: input beat handshake, frame
// status towards the decoder, and the decoder's read/release port.
interface llr_pingpong_loader_if #(
    parameter int NMAX = 1024,
    parameter int P    = 128,
    parameter int Q    = 6,
    parameter int QIN  = 8,
    parameter int L    = 4
) ();
    localparam int AW = ((NMAX / P) > 1) ? $clog2(NMAX / P) : 1;
    localparam int SW = $clog2(NMAX) + 1;

    logic [3:0]       cfg_log2n;
    logic             in_valid;
    logic             in_ready;
    logic [L*QIN-1:0] in_llr;
    logic             frm_valid;
    logic [3:0]       frm_log2n;
    logic [SW-1:0]    frm_sat_cnt;
    logic [AW-1:0]    rd_addr;
    logic [P*Q-1:0]   rd_data;
    logic             frm_release;

    modport slave (
        input  cfg_log2n, in_valid, in_llr, rd_addr, frm_release,
        output in_ready, frm_valid, frm_log2n, frm_sat_cnt, rd_data
    );

    modport master (
        output cfg_log2n, in_valid, in_llr, rd_addr, frm_release,
        input  in_ready, frm_valid, frm_log2n, frm_sat_cnt, rd_data
    );
endinterface

// File: rtl/llr_pingpong_loader.sv
// Channel LLR loader: saturates incoming beats to Q bits, packs them into
// P-slot words and fills two frame banks alternately so one frame can load
// while the decoder reads the other. Frames leave in arrival order.
module llr_pingpong_loader #(
    parameter int NMAX = 1024,
    parameter int P    = 128,
    parameter int Q    = 6,
    parameter int QIN  = 8,
    parameter int L    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    llr_pingpong_loader_if.slave    bus
);
    localparam int LOGN    = $clog2(NMAX);
    localparam int LOGP    = $clog2(P);
    localparam int WMAX    = NMAX / P;
    localparam int AW      = (WMAX > 1) ? $clog2(WMAX) : 1;
    localparam int WCW     = AW + 1;
    localparam int BPW     = P / L;
    localparam int BW      = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int SW      = LOGN + 1;
    localparam int CW      = $clog2(L + 1);
    localparam int SAT_MAX = 2 ** (Q - 1) - 1;

    // Symmetric clip bounds: the most negative Q-bit code is never stored.
    localparam logic signed [QIN-1:0] SAT_HI = QIN'(SAT_MAX);
    localparam logic signed [QIN-1:0] SAT_LO = -SAT_HI;

    logic                 r_wr_bank;
    logic                 r_rd_bank;
    logic [1:0]           r_full;
    logic [BW-1:0]        r_beat;
    logic [AW-1:0]        r_word;
    logic [SW-1:0]        r_sat;
    logic [3:0]           r_cur_log2n;
    logic [3:0]           r_bank_log2n [2];
    logic [SW-1:0]        r_bank_sat   [2];
    logic [P*Q-1:0]       r_pack;
    logic [P*Q-1:0]       r_mem [2][WMAX];
    logic [P*Q-1:0]       r_rd_data;

    logic [3:0]           w_cfg_clamp;
    logic                 w_first;
    logic [3:0]           w_log2n;
    logic [WCW-1:0]       w_words;
    logic [WCW-1:0]       w_rd_words;
    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_beat_last;
    logic                 w_word_last;
    logic                 w_frame_done;
    logic signed [QIN-1:0] w_lane [L];
    logic [L*Q-1:0]       w_group;
    logic [CW-1:0]        w_clip_cnt;
    logic [SW-1:0]        w_sat_next;
    logic [P*Q-1:0]       w_pack_next;

    // Clamp the requested length to what the banks can hold.
    always_comb begin
        w_cfg_clamp = bus.cfg_log2n;
        if (bus.cfg_log2n < 4'(LOGP))
            w_cfg_clamp = 4'(LOGP);
        else if (bus.cfg_log2n > 4'(LOGN))
            w_cfg_clamp = 4'(LOGN);
    end

    // Length is latched on the first beat of a frame; that beat uses it directly.
    assign w_first      = (r_beat == '0) && (r_word == '0);
    assign w_log2n      = w_first ? w_cfg_clamp : r_cur_log2n;
    assign w_words      = WCW'(1) << (w_log2n - 4'(LOGP));
    assign w_in_ready   = !rst && !r_full[r_wr_bank];
    assign w_accept     = bus.in_valid && w_in_ready;
    assign w_beat_last  = (r_beat == BW'(BPW - 1));
    assign w_word_last  = ({1'b0, r_word} == (w_words - WCW'(1)));
    assign w_frame_done = w_accept && w_beat_last && w_word_last;

    // Split the beat into signed lanes.
    always_comb begin
        for (int j = 0; j < L; j++)
            w_lane[j] = $signed(bus.in_llr[j*QIN +: QIN]);
    end

    // Clip each lane to the symmetric range and count the clipped lanes.
    always_comb begin
        w_group    = '0;
        w_clip_cnt = '0;
        for (int j = 0; j < L; j++) begin
            if (w_lane[j] > SAT_HI) begin
                w_group[j*Q +: Q] = SAT_HI[Q-1:0];
                w_clip_cnt        = w_clip_cnt + CW'(1);
            end else if (w_lane[j] < SAT_LO) begin
                w_group[j*Q +: Q] = SAT_LO[Q-1:0];
                w_clip_cnt        = w_clip_cnt + CW'(1);
            end else begin
                w_group[j*Q +: Q] = w_lane[j][Q-1:0];
            end
        end
    end

    assign w_sat_next = r_sat + SW'(w_clip_cnt);

    // Drop the clipped group into its slot of the word being assembled.
    always_comb begin
        w_pack_next = r_pack;
        w_pack_next[r_beat*(L*Q) +: L*Q] = w_group;
    end

    // Write side counters, bank flags and per-bank frame metadata.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_bank       <= 1'b0;
            r_rd_bank       <= 1'b0;
            r_full          <= '0;
            r_beat          <= '0;
            r_word          <= '0;
            r_sat           <= '0;
            r_cur_log2n     <= '0;
            r_pack          <= '0;
            r_bank_log2n[0] <= '0;
            r_bank_log2n[1] <= '0;
            r_bank_sat[0]   <= '0;
            r_bank_sat[1]   <= '0;
        end else begin
            if (w_accept) begin
                r_pack <= w_pack_next;
                if (w_first)
                    r_cur_log2n <= w_cfg_clamp;
                if (w_beat_last) begin
                    r_beat <= '0;
                    r_word <= w_word_last ? '0 : r_word + AW'(1);
                end else begin
                    r_beat <= r_beat + BW'(1);
                end
                r_sat <= w_frame_done ? '0 : w_sat_next;
            end
            if (w_frame_done) begin
                r_full[r_wr_bank]       <= 1'b1;
                r_bank_log2n[r_wr_bank] <= w_log2n;
                r_bank_sat[r_wr_bank]   <= w_sat_next;
                r_wr_bank               <= ~r_wr_bank;
            end
            // A full read bank is never the bank being written, so this
            // cannot collide with the completion update above.
            if (bus.frm_release && r_full[r_rd_bank]) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= ~r_rd_bank;
            end
        end
    end

    // Store a finished word into the write bank.
    always_ff @(posedge clk) begin
        if (w_accept && w_beat_last)
            r_mem[r_wr_bank][r_word] <= w_pack_next;
    end

    assign w_rd_words = WCW'(1) << (r_bank_log2n[r_rd_bank] - 4'(LOGP));

    // Registered read; empty bank or addresses past the frame return zero.
    always_ff @(posedge clk) begin
        if (rst)
            r_rd_data <= '0;
        else if (r_full[r_rd_bank] && ({1'b0, bus.rd_addr} < w_rd_words))
            r_rd_data <= r_mem[r_rd_bank][bus.rd_addr];
        else
            r_rd_data <= '0;
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.frm_valid   = r_full[r_rd_bank];
    assign bus.frm_log2n   = r_bank_log2n[r_rd_bank];
    assign bus.frm_sat_cnt = r_bank_sat[r_rd_bank];
    assign bus.rd_data     = r_rd_data;
endmodule

// File: tb/tb_llr_pingpong_loader.sv
// Randomized bench for the LLR ping-pong loader against a frame-queue model.
module tb_llr_pingpong_loader;
    localparam int NMAX = 1024;
    localparam int P    = 128;
    localparam int Q    = 6;
    localparam int QIN  = 8;
    localparam int L    = 4;
    localparam int DW   = P * Q;
    localparam int WMAX = NMAX / P;

    typedef struct {
        int log2n;
        int sat;
        int llr [NMAX];
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    frame_t fq [$];

    always #5 clk = ~clk;

    llr_pingpong_loader_if #(.NMAX(NMAX), .P(P), .Q(Q), .QIN(QIN), .L(L)) bus ();

    llr_pingpong_loader #(.NMAX(NMAX), .P(P), .Q(Q), .QIN(QIN), .L(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_word(input frame_t f, input int a);
        logic [DW-1:0] w;
        int v;
        w = '0;
        if (a < (1 << f.log2n) / P) begin
            for (int s = 0; s < P; s++) begin
                v = f.llr[a*P + s];
                w[s*Q +: Q] = v[Q-1:0];
            end
        end
        return w;
    endfunction

    task automatic read_word(input int a, output logic [DW-1:0] d);
        bus.rd_addr = 3'(a);
        @(posedge clk);
        #1;
        d = bus.rd_data;
    endtask

    task automatic release_frame();
        bus.frm_release = 1'b1;
        @(posedge clk);
        if (fq.size() > 0) void'(fq.pop_front());
        #1;
        bus.frm_release = 1'b0;
    endtask

    // mode 0: k mod 32, mode 1: fixed saturating pattern, mode 2: random
    task automatic send_frame(input int cfg, input int mode, input int max_beats,
                              input bit rel_last, input bit gaps);
        frame_t f;
        int eff, beats, v, s, t;
        logic [L*QIN-1:0] d;
        bit last;
        eff   = (cfg < 7) ? 7 : ((cfg > 10) ? 10 : cfg);
        beats = (1 << eff) / L;
        f.log2n = eff;
        f.sat   = 0;
        for (int b = 0; b < beats && b < max_beats; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            for (int j = 0; j < L; j++) begin
                case (mode)
                    0: v = (b*L + j) % 32;
                    1: case (j % 4)
                           0: v = 100;
                           1: v = -128;
                           2: v = 31;
                           default: v = -31;
                       endcase
                    default: v = int'($urandom_range(0, 255)) - 128;
                endcase
                d[j*QIN +: QIN] = v[QIN-1:0];
                s = (v > 31) ? 31 : ((v < -31) ? -31 : v);
                if (s != v) f.sat++;
                f.llr[b*L + j] = s;
            end
            bus.cfg_log2n = (b == 0) ? cfg[3:0] : 4'($urandom_range(0, 15));
            bus.in_llr    = d;
            bus.in_valid  = 1'b1;
            t = 0;
            while (!bus.in_ready && t < 200) begin
                @(posedge clk);
                #1;
                t++;
            end
            if (!bus.in_ready) begin
                check("ready_timeout", 1'b0, 1'b1);
                bus.in_valid = 1'b0;
                return;
            end
            last = (b == beats - 1);
            if (last && rel_last) bus.frm_release = 1'b1;
            @(posedge clk);
            if (last && rel_last && fq.size() > 0) void'(fq.pop_front());
            if (last) fq.push_back(f);
            #1;
            bus.in_valid    = 1'b0;
            bus.frm_release = 1'b0;
        end
    endtask

    task automatic verify_front(input string tag);
        frame_t f;
        logic [DW-1:0] d;
        check({tag, "_valid"}, bus.frm_valid, fq.size() > 0);
        check({tag, "_ready"}, bus.in_ready, fq.size() < 2);
        if (fq.size() == 0) begin
            read_word(0, d);
            check({tag, "_empty_rd"}, d, '0);
            return;
        end
        f = fq[0];
        check({tag, "_log2n"}, bus.frm_log2n, f.log2n);
        check({tag, "_sat"}, bus.frm_sat_cnt, f.sat);
        for (int a = 0; a < WMAX; a++) begin
            read_word(a, d);
            check($sformatf("%s_word%0d", tag, a), d, exp_word(f, a));
        end
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] e;
        int tmp;

        bus.cfg_log2n   = 4'd10;
        bus.in_valid    = 1'b0;
        bus.in_llr      = '0;
        bus.rd_addr     = '0;
        bus.frm_release = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", bus.in_ready, 1'b0);
        check("rst_valid", bus.frm_valid, 1'b0);
        check("rst_log2n", bus.frm_log2n, 4'd0);
        check("rst_sat", bus.frm_sat_cnt, '0);
        check("rst_rd_data", bus.rd_data, '0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", bus.in_ready, 1'b1);

        // Full-length frame with a known ramp pattern
        send_frame(10, 0, 1 << 30, 1'b0, 1'b0);
        check("n1024_valid", bus.frm_valid, 1'b1);
        read_word(3, d);
        e = '0;
        for (int s = 0; s < P; s++) begin
            tmp = (384 + s) % 32;
            e[s*Q +: Q] = tmp[Q-1:0];
        end
        check("n1024_addr3", d, e);
        verify_front("n1024");
        release_frame();

        // Saturation pattern
        send_frame(7, 1, 1 << 30, 1'b0, 1'b0);
        check("sat_cnt", bus.frm_sat_cnt, 11'd64);
        verify_front("sat");
        release_frame();

        // Both banks full: backpressure until release
        send_frame(7, 2, 1 << 30, 1'b0, 1'b0);
        send_frame(7, 2, 1 << 30, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check("bp_ready_low", bus.in_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        verify_front("bp_first");
        release_frame();
        check("bp_ready_after_rel", bus.in_ready, 1'b1);
        verify_front("bp_second");
        release_frame();

        // Mixed lengths and clamping
        send_frame(7, 2, 1 << 30, 1'b0, 1'b1);
        send_frame(9, 2, 1 << 30, 1'b0, 1'b1);
        read_word(2, d);
        check("mix_a_addr2_zero", d, '0);
        verify_front("mix_a");
        release_frame();
        verify_front("mix_b");
        release_frame();
        send_frame(3, 2, 1 << 30, 1'b0, 1'b0);
        check("clamp_low", bus.frm_log2n, 4'd7);
        verify_front("clamp_low");
        release_frame();
        send_frame(12, 2, 1 << 30, 1'b0, 1'b0);
        check("clamp_high", bus.frm_log2n, 4'd10);
        verify_front("clamp_high");
        release_frame();

        // Final beat of frame 2 coincides with release of frame 1
        send_frame(7, 2, 1 << 30, 1'b0, 1'b0);
        send_frame(8, 2, 1 << 30, 1'b1, 1'b0);
        check("simul_valid", bus.frm_valid, 1'b1);
        check("simul_ready", bus.in_ready, 1'b1);
        verify_front("simul");
        release_frame();

        // Random frames with gaps and occasional deferred release
        for (int i = 0; i < 6; i++) begin
            if (fq.size() == 2) release_frame();
            send_frame($urandom_range(5, 12), 2, 1 << 30, 1'b0, 1'b1);
            verify_front($sformatf("rand%0d", i));
            if ($urandom_range(0, 1) == 1) release_frame();
        end
        while (fq.size() > 0) release_frame();
        verify_front("drained");

        // Reset mid-frame with a stored frame present
        send_frame(7, 2, 1 << 30, 1'b0, 1'b0);
        send_frame(10, 2, 40, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        fq.delete();
        check("mid_rst_ready", bus.in_ready, 1'b0);
        check("mid_rst_valid", bus.frm_valid, 1'b0);
        check("mid_rst_rd_data", bus.rd_data, '0);
        rst = 1'b0;
        #1;
        check("mid_rst_ready_after", bus.in_ready, 1'b1);
        verify_front("mid_rst_empty");
        send_frame(7, 2, 1 << 30, 1'b0, 1'b0);
        verify_front("after_rst");
        release_frame();
        verify_front("final");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/llr_pingpong_loader.md
Name: llr_pingpong_loader

Overview:
- Parametrised successor to the single-frame serial channel LLR buffer of the SCAN decoder.
- Accepts L channel LLRs per beat over a valid/ready handshake, saturates them from QIN to Q bits, and packs them into P*Q-bit words.
- Stores words in two frame banks (ping-pong), so frame k+1 loads while the decoder consumes frame k.
- Code length is runtime-selectable per frame; the decoder reads packed words by address and releases the bank when done.

Parameters:
- NMAX, 1024: largest code length; power of 2, NMAX >= P.
- P, 128: LLRs per packed word (decoder parallelism); power of 2.
- Q, 6: stored LLR width, signed.
- QIN, 8: input LLR width, signed; QIN >= Q.
- L, 4: LLRs per input beat; power of 2, divides P.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cfg_log2n  in  4  log2 of the code length for the next frame; sampled at the first accepted beat of each frame.
- in_valid  in  1  input beat valid.
- in_ready  out  1  loader can accept a beat.
- in_llr  in  L*QIN  lane j holds LLR index base+j at bits [j*QIN +: QIN].
- frm_valid  out  1  the read bank holds a complete frame.
- frm_log2n  out  4  effective log2 N of the read-bank frame.
- frm_sat_cnt  out  log2(NMAX)+1  number of LLRs clipped in the read-bank frame.
- rd_addr  in  log2(NMAX/P) (min 1)  word address in the read bank.
- rd_data  out  P*Q  packed word; slot s at bits [s*Q +: Q].
- frm_release  in  1  single-cycle pulse: decoder finished with the read bank.

Behaviour:
- Reset:
  - wr_bank = rd_bank = 0; full[1:0] = 0; beat/word counters = 0; packing register = 0; sat counters = 0.
  - Outputs: frm_valid = 0, frm_log2n = 0, frm_sat_cnt = 0, rd_data = 0.
  - in_ready = 0 while rst is high; in_ready = 1 on the first cycle after.
  - rst mid-frame discards the partial frame and both stored frames.
- Length select:
  - cfg_log2n is clamped to [log2 P, log2 NMAX].
  - Effective N = 2^clamped. Words per frame W = N/P; beats per word B = P/L.
- Accept: a beat is taken when in_valid && in_ready. in_ready = !full[wr_bank], combinational from registers only.
- Saturation:
  - Each lane is clamped to the symmetric range [-(2^(Q-1)-1), +(2^(Q-1)-1)]; for Q=6 that is ±31, and -32 never appears.
  - Each clipped lane increments the write-bank sat counter by 1. A beat with several clipped lanes adds the count of clipped lanes.
- Packing:
  - LLR index k goes to word k/P, slot k%P. The beat counter indexes the L-slot group inside the word.
  - When beat B of a word is accepted, the full word is written to mem[wr_bank][word] on that clock edge, and the word counter increments.
- Frame completion: on acceptance of the last beat of word W-1, on the same edge:
  - full[wr_bank] <= 1.
  - The bank's log2n and sat count are stored.
  - wr_bank toggles; beat, word and sat counters clear.
  - in_ready in the next cycle reflects full of the new wr_bank.
- Read side:
  - frm_valid = full[rd_bank]; frm_log2n and frm_sat_cnt are the stored values of rd_bank.
  - rd_data is registered, 1-cycle latency: rd_data <= (rd_addr < W_rd) ? mem[rd_bank][rd_addr] : 0.
  - Reads while !frm_valid return 0.
- Release:
  - frm_release while frm_valid clears full[rd_bank] and toggles rd_bank on that edge.
  - frm_release while !frm_valid is ignored.
- Simultaneous events:
  - Frame completion and release of the other bank in the same cycle both take effect.
  - Both banks full: in_ready = 0 until a release. The next cycle after that release, in_ready = 1.
- Ordering: frames are delivered strictly in arrival order. rd_bank never overtakes wr_bank.

Test Plan:
- Reset, then N=1024 (cfg_log2n=10), L=4, in_llr lanes = k mod 32 → 256 beats; frm_valid rises the cycle after beat 256. rd_addr=3 → next cycle slot s = (384+s) mod 32. frm_sat_cnt=0.
- Saturation: lanes {+100, -128, +31, -31} with Q=6 → stored {+31, -31, +31, -31}; frm_sat_cnt = 2 per such beat.
- Ping-pong backpressure: load two N=128 frames with no release → in_ready=0 after beat 64, stays 0 for 10 cycles. Pulse frm_release → in_ready=1 next cycle; second frame is presented with rd_bank=1.
- Mixed lengths: frame A cfg_log2n=7, frame B cfg_log2n=9 → frm_log2n 7 then 9. rd_addr=2 on frame A returns 0. Out-of-range cfg_log2n=3 clamps to 7; cfg_log2n=12 clamps to 10.
- Simultaneous: the final beat of frame 2 is accepted in the same cycle as release of frame 1 → frm_valid stays 1 (frame 2), and in_ready=1 next cycle.
- Reset mid-frame after 40 beats with frame 1 stored → all flags clear, rd_data=0. A fresh N=128 frame then loads correctly into bank 0.
